// File: rtl/pipe_ifu_fq.sv
// Instruction fetch unit with credit-based fetch queue.
// Issues in-order word fetches, queues responses for ID and handles redirects with stale-response dropping.
module pipe_ifu_fq #(
   parameter logic [31:0] RESET_PC  = 32'h8000_0000,
   parameter int unsigned FQ_DEPTH  = 4,
   parameter int unsigned MAX_OUTST = 2
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic                             flush_i,
   input  logic [31:0]                      flush_pc_i,
   output logic                             mem_req_valid_o,
   output logic [31:0]                      mem_req_addr_o,
   input  logic                             mem_req_ready_i,
   input  logic                             mem_resp_valid_i,
   input  logic [31:0]                      mem_resp_data_i,
   input  logic                             mem_resp_err_i,
   output logic                             if_valid_o,
   output logic [31:0]                      if_pc_o,
   output logic [31:0]                      if_inst_o,
   output logic                             if_fault_o,
   input  logic                             id_ready_i,
   output logic [$clog2(FQ_DEPTH+1)-1:0]    fq_count_o
);

   localparam int unsigned CW = $clog2(FQ_DEPTH + 1);
   localparam int unsigned PW = $clog2(FQ_DEPTH);
   localparam int unsigned IW = $clog2(MAX_OUTST + 1);

   logic [31:0]   fetch_pc;
   logic [31:0]   resp_pc;
   logic [31:0]   fq_pc    [FQ_DEPTH];
   logic [31:0]   fq_inst  [FQ_DEPTH];
   logic          fq_fault [FQ_DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [IW-1:0] inflight;
   logic [IW-1:0] drop_cnt;
   logic          halt;

   logic          issue_c;
   logic          req_fire_c;
   logic          push_c;
   logic          drop_c;
   logic          pop_c;

   // Credits cover both in-flight requests and queued entries, so the queue can never overflow.
   always_comb begin
      issue_c    = 1'b0;
      req_fire_c = 1'b0;
      push_c     = 1'b0;
      drop_c     = 1'b0;
      pop_c      = 1'b0;
      issue_c    = ~rst_i & ~flush_i & ~halt
                   & (32'(inflight) < MAX_OUTST)
                   & ((32'(inflight) + 32'(count)) < FQ_DEPTH);
      req_fire_c = issue_c & mem_req_ready_i;
      push_c     = mem_resp_valid_i & ~flush_i & (drop_cnt == '0);
      drop_c     = mem_resp_valid_i & ~flush_i & (drop_cnt != '0);
      pop_c      = (count != '0) & ~flush_i & id_ready_i;
   end

   assign mem_req_valid_o = issue_c;
   assign mem_req_addr_o  = fetch_pc;
   assign if_valid_o      = (count != '0) & ~flush_i;
   assign if_pc_o         = fq_pc[rd_ptr];
   assign if_inst_o       = fq_inst[rd_ptr];
   assign if_fault_o      = fq_fault[rd_ptr];
   assign fq_count_o      = count;

   // Control state; a flush discards everything still in flight by arming drop_cnt.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fetch_pc <= {RESET_PC[31:2], 2'b00};
         resp_pc  <= {RESET_PC[31:2], 2'b00};
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         inflight <= '0;
         drop_cnt <= '0;
         halt     <= 1'b0;
      end else begin
         inflight <= inflight + IW'(req_fire_c) - IW'(mem_resp_valid_i);
         if (flush_i) begin
            fetch_pc <= {flush_pc_i[31:2], 2'b00};
            resp_pc  <= {flush_pc_i[31:2], 2'b00};
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            halt     <= 1'b0;
            drop_cnt <= inflight - IW'(mem_resp_valid_i);
         end else begin
            if (req_fire_c) begin
               fetch_pc <= fetch_pc + 32'd4;
            end
            if (push_c) begin
               wr_ptr  <= wr_ptr + PW'(1);
               resp_pc <= resp_pc + 32'd4;
               if (mem_resp_err_i) begin
                  halt <= 1'b1;
               end
            end
            if (pop_c) begin
               rd_ptr <= rd_ptr + PW'(1);
            end
            if (drop_c) begin
               drop_cnt <= drop_cnt - IW'(1);
            end
            count <= count + CW'(push_c) - CW'(pop_c);
         end
      end
   end

   // Queue payload storage; contents are only meaningful below count.
   always_ff @(posedge clk_i) begin
      if (push_c) begin
         fq_pc[wr_ptr]    <= resp_pc;
         fq_inst[wr_ptr]  <= mem_resp_data_i;
         fq_fault[wr_ptr] <= mem_resp_err_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i && push_c) begin
         assert (count != CW'(FQ_DEPTH));
      end
   end

endmodule

// File: tb/tb_pipe_ifu_fq.sv
// Bench for pipe_ifu_fq: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_pipe_ifu_fq;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned MAXO  = 2;
   localparam logic [31:0] RPC   = 32'h8000_0000;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        flush_i;
   logic [31:0] flush_pc_i;
   logic        mem_req_valid_o;
   logic [31:0] mem_req_addr_o;
   logic        mem_req_ready_i;
   logic        mem_resp_valid_i;
   logic [31:0] mem_resp_data_i;
   logic        mem_resp_err_i;
   logic        if_valid_o;
   logic [31:0] if_pc_o;
   logic [31:0] if_inst_o;
   logic        if_fault_o;
   logic        id_ready_i;
   logic [2:0]  fq_count_o;

   always #5 clk_i = ~clk_i;

   pipe_ifu_fq #(.RESET_PC(RPC), .FQ_DEPTH(DEPTH), .MAX_OUTST(MAXO)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .flush_pc_i(flush_pc_i),
      .mem_req_valid_o(mem_req_valid_o), .mem_req_addr_o(mem_req_addr_o),
      .mem_req_ready_i(mem_req_ready_i), .mem_resp_valid_i(mem_resp_valid_i),
      .mem_resp_data_i(mem_resp_data_i), .mem_resp_err_i(mem_resp_err_i),
      .if_valid_o(if_valid_o), .if_pc_o(if_pc_o), .if_inst_o(if_inst_o),
      .if_fault_o(if_fault_o), .id_ready_i(id_ready_i), .fq_count_o(fq_count_o)
   );

   typedef struct {logic [31:0] pc; logic [31:0] inst; logic fault;} ent_t;
   typedef struct {logic [31:0] addr; int due;} req_t;

   ent_t        mq[$];
   req_t        memq[$];
   logic [31:0] m_fetch, m_resp;
   int          m_infl, m_drop;
   bit          m_halt;

   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   int          p_ready, p_idr, p_flush, p_err, lat_min, lat_max, flush_mode;
   bit          tgt_en, err_en, flushed;
   logic [31:0] tgt_pc, err_addr;

   logic        s_valid, s_ifv, s_fault;
   logic [31:0] s_addr, s_pc;
   logic [2:0]  s_count;

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h cyc=%0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      memq.delete();
      m_fetch = RPC;
      m_resp  = RPC;
      m_infl  = 0;
      m_drop  = 0;
      m_halt  = 0;
   endtask

   // One clock cycle: drive inputs, check outputs against the model, then advance the model.
   task automatic step(input bit rst);
      bit          resp, flush, fire, pop, ev, eifv;
      logic [31:0] rdata, fpc;
      logic        rerr;
      ent_t        e;
      req_t        r;
      @(posedge clk_i);
      #1;
      resp  = 0;
      rdata = '0;
      rerr  = 1'b0;
      if (!rst && memq.size() > 0 && memq[0].due <= cyc) begin
         resp  = 1;
         rdata = inst_of(memq[0].addr);
         rerr  = (err_en && memq[0].addr == err_addr) || ($urandom_range(99) < 32'(p_err));
      end
      case (flush_mode)
         1:       flush = resp && m_infl == 2;
         2:       flush = m_infl == 2;
         3:       flush = 1;
         default: flush = $urandom_range(99) < 32'(p_flush);
      endcase
      if (rst) flush = 0;
      fpc = tgt_en ? tgt_pc : $urandom;
      rst_i            = rst;
      flush_i          = flush;
      flush_pc_i       = fpc;
      mem_req_ready_i  = $urandom_range(99) < 32'(p_ready);
      mem_resp_valid_i = resp;
      mem_resp_data_i  = rdata;
      mem_resp_err_i   = rerr;
      id_ready_i       = $urandom_range(99) < 32'(p_idr);
      #2;
      ev   = !rst && !flush && !m_halt && m_infl < int'(MAXO) && (m_infl + mq.size()) < int'(DEPTH);
      eifv = mq.size() != 0 && !flush;
      s_valid = mem_req_valid_o; s_addr = mem_req_addr_o; s_ifv = if_valid_o;
      s_pc = if_pc_o; s_fault = if_fault_o; s_count = fq_count_o;
      chk("req_valid", 32'(mem_req_valid_o), 32'(ev));
      if (ev) chk("req_addr", mem_req_addr_o, m_fetch);
      if (!rst) begin
         chk("if_valid", 32'(if_valid_o), 32'(eifv));
         chk("fq_count", 32'(fq_count_o), 32'(mq.size()));
         if (eifv) begin
            chk("if_pc", if_pc_o, mq[0].pc);
            chk("if_inst", if_inst_o, mq[0].inst);
            chk("if_fault", 32'(if_fault_o), 32'(mq[0].fault));
         end
      end
      if (rst) begin
         model_reset();
      end else begin
         fire = ev && mem_req_ready_i;
         pop  = eifv && id_ready_i;
         if (resp) void'(memq.pop_front());
         if (fire) begin
            r.addr = m_fetch;
            r.due  = cyc + int'($urandom_range(32'(lat_max), 32'(lat_min)));
            memq.push_back(r);
            m_fetch += 32'd4;
         end
         m_infl = m_infl + int'(fire) - int'(resp);
         if (flush) begin
            mq.delete();
            m_fetch = {fpc[31:2], 2'b00};
            m_resp  = {fpc[31:2], 2'b00};
            m_halt  = 0;
            m_drop  = m_infl;
            flushed = 1;
         end else begin
            if (pop) void'(mq.pop_front());
            if (resp) begin
               if (m_drop > 0) m_drop--;
               else begin
                  e.pc = m_resp; e.inst = rdata; e.fault = rerr;
                  mq.push_back(e);
                  m_resp += 32'd4;
                  if (rerr) m_halt = 1;
               end
            end
         end
      end
      cyc++;
   endtask

   task automatic run_until_flush(input string tag);
      flushed = 0;
      for (int i = 0; i < 60 && !flushed; i++) step(0);
      chk(tag, 32'(flushed), 32'd1);
      flush_mode = 0;
      tgt_en     = 0;
   endtask

   task automatic wait_ifv(input string tag, input logic [31:0] exp_pc);
      bit got = 0;
      for (int i = 0; i < 60 && !got; i++) begin
         step(0);
         if (s_ifv) got = 1;
      end
      chk({tag, "_seen"}, 32'(got), 32'd1);
      chk({tag, "_pc"}, s_pc, exp_pc);
   endtask

   initial begin
      logic [31:0] held;
      bit          got;
      rst_i = 1; flush_i = 0; flush_pc_i = '0; mem_req_ready_i = 0;
      mem_resp_valid_i = 0; mem_resp_data_i = '0; mem_resp_err_i = 0; id_ready_i = 0;
      p_ready = 100; p_idr = 100; p_flush = 0; p_err = 0; lat_min = 1; lat_max = 1;
      flush_mode = 0; tgt_en = 0; err_en = 0; flushed = 0; tgt_pc = '0; err_addr = '0;
      model_reset();

      // Reset state and sequential fetch from RESET_PC
      step(1);
      step(1);
      chk("rst_req_valid", 32'(s_valid), 32'd0);
      step(0);
      chk("post_rst_count", 32'(s_count), 32'd0);
      chk("post_rst_ifv", 32'(s_ifv), 32'd0);
      chk("post_rst_valid", 32'(s_valid), 32'd1);
      chk("post_rst_addr", s_addr, 32'h8000_0000);
      repeat (30) step(0);

      // ID stall fills the queue, issue stops, then resumes
      p_idr = 0;
      repeat (20) step(0);
      chk("full_count", 32'(s_count), 32'd4);
      chk("full_noreq", 32'(s_valid), 32'd0);
      p_idr = 100;
      repeat (12) step(0);

      // Flush with two requests in flight
      lat_min = 3; lat_max = 3;
      repeat (5) step(0);
      tgt_en = 1; tgt_pc = 32'h8000_1000; flush_mode = 2;
      run_until_flush("flush2_hit");
      wait_ifv("flush2_first", 32'h8000_1000);
      repeat (10) step(0);

      // Flush coinciding with a response at inflight=2
      step(1);
      lat_min = 2; lat_max = 2;
      tgt_en = 1; tgt_pc = 32'h8000_2003; flush_mode = 1;
      run_until_flush("flush_resp_hit");
      wait_ifv("flush_resp_first", 32'h8000_2000);
      repeat (10) step(0);

      // Access fault halts fetch until redirect
      step(1);
      lat_min = 1; lat_max = 1;
      err_en = 1; err_addr = 32'h8000_0008;
      got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         step(0);
         if (s_ifv && s_fault) got = 1;
      end
      chk("fault_seen", 32'(got), 32'd1);
      chk("fault_pc", s_pc, 32'h8000_0008);
      err_en = 0;
      repeat (8) step(0);
      chk("halt_noreq", 32'(s_valid), 32'd0);
      tgt_en = 1; tgt_pc = 32'h8000_0100; flush_mode = 3;
      run_until_flush("halt_flush");
      wait_ifv("resume", 32'h8000_0100);

      // Memory backpressure keeps the pending request stable
      p_ready = 0;
      repeat (3) step(0);
      held = s_addr;
      chk("stall_valid", 32'(s_valid), 32'd1);
      repeat (5) begin
         step(0);
         chk("stall_addr", s_addr, held);
         chk("stall_hold", 32'(s_valid), 32'd1);
      end
      p_ready = 100;
      repeat (5) step(0);

      // Randomized traffic with flushes, faults and occasional resets
      repeat (20) begin
         p_ready = int'($urandom_range(100, 20));
         p_idr   = int'($urandom_range(100, 0));
         p_flush = int'($urandom_range(10, 0));
         p_err   = int'($urandom_range(10, 0));
         lat_min = int'($urandom_range(2, 1));
         lat_max = lat_min + int'($urandom_range(3, 0));
         repeat (100) step($urandom_range(199) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
